sprite_line_fetch: RTL

//  Upstream feeder for the per-sprite pixel units. During horizontal blank it scans the sprite

---
 rtl/sprite_pkg.sv | 46 ++++
 rtl/sprite_slot_bank.sv | 73 +++++++
 rtl/sprite_line_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line fetcher: attribute word layout, slot record,
// pattern addressing helpers and the scan FSM encoding.
package sprite_pkg;

  localparam int SPR_H  = 16;
  localparam int PAT_W  = 32;
  localparam int TILE_W = 6;
  localparam int ROW_W  = 4;
  localparam int PAT_AW = TILE_W + ROW_W;
  localparam int POSX_W = 9;
  localparam int SCLX_W = 4;

  localparam int ATTR_EN      = 31;
  localparam int ATTR_SWPX    = 30;
  localparam int ATTR_SWPY    = 29;
  localparam int ATTR_SCLX_HI = 28;
  localparam int ATTR_SCLX_LO = 25;
  localparam int ATTR_POSX_HI = 24;
  localparam int ATTR_POSX_LO = 16;
  localparam int ATTR_POSY_HI = 15;
  localparam int ATTR_POSY_LO = 8;
  localparam int ATTR_TILE_HI = 7;
  localparam int ATTR_TILE_LO = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARD,
    ST_AEVAL,
    ST_PRD,
    ST_PST
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              swpX;
    logic [SCLX_W-1:0] sclX;
    logic [POSX_W-1:0] posX;
    logic [PAT_W-1:0]  colors;
  } slot_t;

  // Vertical mirror reads the sprite's rows bottom-up.
  function automatic logic [ROW_W-1:0] pat_row(input logic [ROW_W-1:0] row, input logic swp_y);
    return swp_y ? (ROW_W'(SPR_H - 1) - row) : row;
  endfunction

endpackage

// File: rtl/sprite_slot_bank.sv
// Working and display slot register sets. The scan writes the working set one slot at a time;
// a swap publishes it whole to the display set so the pixel units never see a half-built line.
import sprite_pkg::*;

module sprite_slot_bank #(
  parameter int NSPR = 8,
  parameter int SW   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_wr_en,
  input  logic [SW-1:0]            i_wr_slot,
  input  logic [PAT_W-1:0]         i_wr_colors,
  input  logic [POSX_W-1:0]        i_wr_posX,
  input  logic [SCLX_W-1:0]        i_wr_sclX,
  input  logic                     i_wr_swpX,
  input  logic                     i_swap,
  input  logic                     i_kill,
  output logic [NSPR*PAT_W-1:0]    o_colors,
  output logic [NSPR*POSX_W-1:0]   o_posX,
  output logic [NSPR*SCLX_W-1:0]   o_sclX,
  output logic [NSPR-1:0]          o_swpX,
  output logic [NSPR-1:0]          o_valid
);

  slot_t r_work [NSPR];
  slot_t r_disp [NSPR];
  slot_t w_wr;

  assign w_wr.valid  = 1'b1;
  assign w_wr.swpX   = i_wr_swpX;
  assign w_wr.sclX   = i_wr_sclX;
  assign w_wr.posX   = i_wr_posX;
  assign w_wr.colors = i_wr_colors;

  // Swap reads the pre-edge working set, so a coincident clear still publishes the old line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NSPR; i++) begin
        r_work[i] <= '0;
        r_disp[i] <= '0;
      end
    end else begin
      if (i_swap) begin
        for (int i = 0; i < NSPR; i++) r_disp[i] <= r_work[i];
      end else if (i_kill) begin
        for (int i = 0; i < NSPR; i++) r_disp[i] <= '0;
      end
      if (i_clear) begin
        for (int i = 0; i < NSPR; i++) r_work[i] <= '0;
      end else if (i_wr_en) begin
        r_work[i_wr_slot] <= w_wr;
      end
    end
  end

  always_comb begin
    o_colors = '0;
    o_posX   = '0;
    o_sclX   = '0;
    o_swpX   = '0;
    o_valid  = '0;
    for (int i = 0; i < NSPR; i++) begin
      o_colors[PAT_W*i +: PAT_W]   = r_disp[i].colors;
      o_posX[POSX_W*i +: POSX_W]   = r_disp[i].posX;
      o_sclX[SCLX_W*i +: SCLX_W]   = r_disp[i].sclX;
      o_swpX[i]                    = r_disp[i].swpX;
      o_valid[i]                   = r_disp[i].valid;
    end
  end

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-line sprite selection: scans the attribute table during hblank, fetches pattern rows for
// up to NSPR covering sprites, and hands the slot bank a double-buffered set for the next line.
import sprite_pkg::*;

module sprite_line_fetch #(
  parameter int NSPR  = 8,
  parameter int NATTR = 32,
  parameter int AW    = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_line_start,
  input  logic [7:0]              i_next_y,
  input  logic                    i_line_swap,
  output logic [AW-1:0]           o_attr_addr,
  input  logic [31:0]             i_attr_data,
  output logic [PAT_AW-1:0]       o_pat_addr,
  input  logic [PAT_W-1:0]        i_pat_data,
  output logic [NSPR*PAT_W-1:0]   o_spr_colors,
  output logic [NSPR*POSX_W-1:0]  o_spr_posX,
  output logic [NSPR*SCLX_W-1:0]  o_spr_sclX,
  output logic [NSPR-1:0]         o_spr_swpX,
  output logic [NSPR-1:0]         o_spr_valid,
  output logic                    o_busy,
  output logic                    o_overflow,
  output logic                    o_late
);

  localparam int CW = $clog2(NSPR + 1);
  localparam int SW = (NSPR > 1) ? $clog2(NSPR) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_y;
  logic [PAT_AW-1:0]   r_pat_addr;
  logic [POSX_W-1:0]   r_posX;
  logic [SCLX_W-1:0]   r_sclX;
  logic                r_swpX;
  logic                r_ovf;
  logic                r_late;

  logic [7:0]          w_row;
  logic                w_hit;
  logic                w_last;
  logic                w_full;
  logic                w_busy;
  logic                w_unused;

  // Row wraps mod 256 so sprites straddling the top of the frame still hit.
  assign w_row    = r_y - i_attr_data[ATTR_POSY_HI:ATTR_POSY_LO];
  assign w_hit    = i_attr_data[ATTR_EN] && (w_row < 8'(SPR_H));
  assign w_last   = (r_idx == AW'(NATTR - 1));
  assign w_full   = (r_cnt == CW'(NSPR));
  assign w_busy   = (r_state != ST_IDLE);
  assign w_unused = ^i_attr_data[1:0];

  assign o_attr_addr = r_idx;
  assign o_pat_addr  = r_pat_addr;
  assign o_busy      = w_busy;
  assign o_overflow  = r_ovf;
  assign o_late      = r_late;

  // Once all slots are full, entries are only evaluated; the first further hit ends the scan.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  w_state_nxt = ST_IDLE;
      ST_ARD:   w_state_nxt = ST_AEVAL;
      ST_AEVAL: begin
        if (w_hit && !w_full)    w_state_nxt = ST_PRD;
        else if (w_hit || w_last) w_state_nxt = ST_IDLE;
        else                      w_state_nxt = ST_ARD;
      end
      ST_PRD:   w_state_nxt = ST_PST;
      ST_PST:   w_state_nxt = w_last ? ST_IDLE : ST_ARD;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (i_line_start) w_state_nxt = ST_ARD;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_y        <= '0;
      r_pat_addr <= '0;
      r_posX     <= '0;
      r_sclX     <= '0;
      r_swpX     <= 1'b0;
      r_ovf      <= 1'b0;
      r_late     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_late  <= i_line_swap && w_busy;
      if (i_line_start) begin
        r_idx <= '0;
        r_cnt <= '0;
        r_y   <= i_next_y;
      end else begin
        unique case (r_state)
          ST_AEVAL: begin
            if (w_hit && !w_full) begin
              r_pat_addr <= {i_attr_data[ATTR_TILE_HI:ATTR_TILE_LO],
                             pat_row(w_row[ROW_W-1:0], i_attr_data[ATTR_SWPY])};
              r_posX     <= i_attr_data[ATTR_POSX_HI:ATTR_POSX_LO];
              r_sclX     <= i_attr_data[ATTR_SCLX_HI:ATTR_SCLX_LO];
              r_swpX     <= i_attr_data[ATTR_SWPX];
            end else if (w_hit) begin
              r_ovf <= 1'b1;
            end else if (w_last) begin
              r_ovf <= 1'b0;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
          ST_PST: begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_ovf <= 1'b0;
            else        r_idx <= r_idx + AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  sprite_slot_bank #(
    .NSPR (NSPR),
    .SW   (SW)
  ) u_bank (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_line_start),
    .i_wr_en     ((r_state == ST_PST) && !i_line_start),
    .i_wr_slot   (r_cnt[SW-1:0]),
    .i_wr_colors (i_pat_data),
    .i_wr_posX   (r_posX),
    .i_wr_sclX   (r_sclX),
    .i_wr_swpX   (r_swpX),
    .i_swap      (i_line_swap && !w_busy),
    .i_kill      (i_line_swap && w_busy),
    .o_colors    (o_spr_colors),
    .o_posX      (o_spr_posX),
    .o_sclX      (o_spr_sclX),
    .o_swpX      (o_spr_swpX),
    .o_valid     (o_spr_valid)
  );

endmodule
